// File: rtl/twiddle_table_loader_pkg.sv
// Shared definitions for the twiddle table loader: ring/butterfly sizing,
// derived RAM geometry and the loader state type.
package FHE_ALU_PKG;

    localparam int FSIZE          = 16;
    localparam int E              = 4;
    localparam int logE           = 2;
    localparam int N              = 16;
    localparam int ROOT_POWER_NUM = 4;

    localparam int D  = N / (E / 2);
    localparam int AW = (D > 1) ? $clog2(D) : 1;
    localparam int RW = (ROOT_POWER_NUM > 1) ? $clog2(ROOT_POWER_NUM) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } twl_state_t;

    // Counter width helper that never returns zero, so one-entry ranges still get a bit.
    function automatic int clogMin1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/twiddle_table_loader_packer.sv
// Collects consecutive coefficient beats into one RAM word of LANES lanes,
// flagging the beat that completes the word.
module twiddle_lane_packer #(
    parameter int FSIZE = FHE_ALU_PKG::FSIZE,
    parameter int LANES = FHE_ALU_PKG::E / 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_beat,
    input  logic                        i_clear,
    input  logic [FSIZE-1:0]            i_data,
    output logic                        o_wordDone,
    output logic [LANES-1:0][FSIZE-1:0] o_word
);
    import FHE_ALU_PKG::*;

    localparam int LW = clogMin1(LANES);

    logic [LW-1:0]              r_laneCnt;
    logic [LANES-1:0][FSIZE-1:0] r_pack;
    logic                       w_lastLane;

    assign w_lastLane = (r_laneCnt == LW'(LANES - 1));
    assign o_wordDone = i_beat & w_lastLane;

    // The completing beat is merged in here so the word can be registered in the same cycle.
    always_comb begin
        o_word = r_pack;
        if (i_beat) begin
            o_word[r_laneCnt] = i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_laneCnt <= '0;
            r_pack    <= '0;
        end else if (i_beat) begin
            r_pack[r_laneCnt] <= i_data;
            r_laneCnt         <= w_lastLane ? '0 : r_laneCnt + 1'b1;
        end
    end

endmodule

// File: rtl/twiddle_table_loader.sv
// Streams one W or WQ twiddle table per command into the root-power RAMs.
// Optional macro TWIDDLE_LOADER_BCAST_EN lets a command write every RAM at once.
module twiddle_table_loader #(
    parameter  int FSIZE  = FHE_ALU_PKG::FSIZE,
    parameter  int E      = FHE_ALU_PKG::E,
    parameter  int LOGE   = FHE_ALU_PKG::logE,
    parameter  int N      = FHE_ALU_PKG::N,
    parameter  int RP_NUM = FHE_ALU_PKG::ROOT_POWER_NUM,
    localparam int AW     = (N / (E / 2) > 1) ? $clog2(N / (E / 2)) : 1,
    localparam int RW     = (RP_NUM > 1) ? $clog2(RP_NUM) : 1
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           cmd_valid,
    output logic                                           cmd_ready,
    input  logic [RW-1:0]                                  cmd_ram,
    input  logic                                           cmd_wq,
    input  logic                                           cmd_bcast,
    input  logic                                           s_valid,
    output logic                                           s_ready,
    input  logic [FSIZE-1:0]                               s_data,
    output logic                                           busy,
    output logic                                           done,
    output logic [RP_NUM-1:0][LOGE-1:0][E/2-1:0][FSIZE-1:0] W_ram_wdata,
    output logic [RP_NUM-1:0][LOGE-1:0][E/2-1:0][FSIZE-1:0] WQ_ram_wdata,
    output logic [RP_NUM-1:0][LOGE-1:0][E/2-1:0]            W_ram_wren,
    output logic [RP_NUM-1:0][LOGE-1:0][E/2-1:0]            WQ_ram_wren,
    output logic [RP_NUM-1:0][LOGE-1:0][AW-1:0]             W_ram_waddr,
    output logic [RP_NUM-1:0][LOGE-1:0][AW-1:0]             WQ_ram_waddr
);
    import FHE_ALU_PKG::*;

    localparam int LANES   = E / 2;
    localparam int DEPTH   = N / LANES;
    localparam int STAGE_W = clogMin1(LOGE);

    twl_state_t r_state, w_stateNext;

    logic [RW-1:0]      r_ram;
    logic               r_wq;
    logic               r_bcast;
    logic [AW-1:0]      r_addrCnt;
    logic [STAGE_W-1:0] r_stageCnt;

    logic w_cmdAccept;
    logic w_beat;
    logic w_wordDone;
    logic w_lastWord;
    logic w_bcast;

    logic [LANES-1:0][FSIZE-1:0]        w_word;
    logic [LANES-1:0][FSIZE-1:0]        r_wdata;
    logic [AW-1:0]                      r_waddr;
    logic [RP_NUM-1:0][LOGE-1:0][LANES-1:0] w_wren;
    logic [RP_NUM-1:0][LOGE-1:0][LANES-1:0] r_wrenW;
    logic [RP_NUM-1:0][LOGE-1:0][LANES-1:0] r_wrenWQ;

    assign cmd_ready   = (r_state == IDLE);
    assign s_ready     = (r_state == LOAD);
    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE);
    assign w_cmdAccept = cmd_valid & cmd_ready;
    assign w_beat      = s_valid & s_ready;
    assign w_lastWord  = w_wordDone && (r_addrCnt == AW'(DEPTH - 1))
                         && (r_stageCnt == STAGE_W'(LOGE - 1));

`ifdef TWIDDLE_LOADER_BCAST_EN
    assign w_bcast = r_bcast;
`else
    // Port kept for pin compatibility; single-target builds discard its value.
    assign w_bcast = 1'b0 & r_bcast;
`endif

    twiddle_lane_packer #(
        .FSIZE (FSIZE),
        .LANES (LANES)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .i_beat     (w_beat),
        .i_clear    (w_cmdAccept),
        .i_data     (s_data),
        .o_wordDone (w_wordDone),
        .o_word     (w_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (w_cmdAccept) w_stateNext = LOAD;
            LOAD:    if (w_lastWord)  w_stateNext = DONE;
            DONE:    w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ram   <= '0;
            r_wq    <= 1'b0;
            r_bcast <= 1'b0;
        end else if (w_cmdAccept) begin
            r_ram   <= cmd_ram;
            r_wq    <= cmd_wq;
            r_bcast <= cmd_bcast;
        end
    end

    // Address walks every word of a stage before the stage index advances.
    always_ff @(posedge clk) begin
        if (rst || w_cmdAccept) begin
            r_addrCnt  <= '0;
            r_stageCnt <= '0;
        end else if (w_wordDone) begin
            if (r_addrCnt == AW'(DEPTH - 1)) begin
                r_addrCnt  <= '0;
                r_stageCnt <= (r_stageCnt == STAGE_W'(LOGE - 1)) ? '0 : r_stageCnt + 1'b1;
            end else begin
                r_addrCnt <= r_addrCnt + 1'b1;
            end
        end
    end

    // An out-of-range RAM index matches no r, so the table is consumed with no writes.
    always_comb begin
        w_wren = '0;
        if (w_wordDone) begin
            for (int r = 0; r < RP_NUM; r++) begin
                if (w_bcast || (r_ram == RW'(r))) begin
                    w_wren[r][r_stageCnt] = '1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrenW  <= '0;
            r_wrenWQ <= '0;
            r_wdata  <= '0;
            r_waddr  <= '0;
        end else begin
            r_wrenW  <= r_wq ? '0 : w_wren;
            r_wrenWQ <= r_wq ? w_wren : '0;
            if (w_wordDone) begin
                r_wdata <= w_word;
                r_waddr <= r_addrCnt;
            end
        end
    end

    assign W_ram_wren   = r_wrenW;
    assign WQ_ram_wren  = r_wrenWQ;
    assign W_ram_wdata  = {(RP_NUM * LOGE){r_wdata}};
    assign WQ_ram_wdata = {(RP_NUM * LOGE){r_wdata}};
    assign W_ram_waddr  = {(RP_NUM * LOGE){r_waddr}};
    assign WQ_ram_waddr = {(RP_NUM * LOGE){r_waddr}};

endmodule
